// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: oversampled UART receiver with configurable data/stop bits.
// Define UART_RX_PARITY_EN to receive a parity bit after the data bits.
module uart_rx_cfg #(
  parameter int NB_DATA    = 8,
  parameter int NB_STOP    = 1,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_tick,
  input  logic               i_rx_data,
  output logic [NB_DATA-1:0] o_data,
  output logic               o_valid,
  output logic               o_frame_err,
  output logic               o_parity_err
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    DATA_LAST = 4'(NB_DATA - 1);
  localparam logic [3:0]    STOP_LAST = 4'(NB_STOP - 1);

  if (NB_DATA < 5 || NB_DATA > 9 || NB_STOP < 1 || NB_STOP > 2 ||
      OVERSAMPLE < 8 || OVERSAMPLE > 32 || (OVERSAMPLE % 2) != 0 ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
    $fatal(1, "uart_rx_cfg: parameter out of range");
  end

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t               state, state_n;
  logic [1:0]           sync;
  logic                 rx, rx_prev;
  logic [TW-1:0]        tick_cnt, tick_cnt_n;
  logic [3:0]           bit_cnt, bit_cnt_n;
  logic [NB_DATA-1:0]   shreg, shreg_n;
  logic                 ferr, ferr_n;
  logic [NB_DATA-1:0]   data_n;
  logic                 valid_n, frame_err_n;

  assign rx = sync[1];

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_bit_n, parity_err_n;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync        <= '1;
      rx_prev     <= 1'b1;
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      ferr        <= 1'b0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
    end else begin
      sync        <= {sync[0], i_rx_data};
      rx_prev     <= rx;
      state       <= state_n;
      tick_cnt    <= tick_cnt_n;
      bit_cnt     <= bit_cnt_n;
      shreg       <= shreg_n;
      ferr        <= ferr_n;
      o_data      <= data_n;
      o_valid     <= valid_n;
      o_frame_err <= frame_err_n;
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      par_bit      <= 1'b0;
      o_parity_err <= 1'b0;
    end else begin
      par_bit      <= par_bit_n;
      o_parity_err <= parity_err_n;
    end
  end
`else
  assign o_parity_err = 1'b0;
`endif

  // Start detection needs a fresh high-to-low edge, so a line held low after
  // a frame error (a break) cannot retrigger reception.
  always_comb begin
    state_n     = state;
    tick_cnt_n  = tick_cnt;
    bit_cnt_n   = bit_cnt;
    shreg_n     = shreg;
    ferr_n      = ferr;
    data_n      = o_data;
    valid_n     = 1'b0;
    frame_err_n = o_frame_err;
`ifdef UART_RX_PARITY_EN
    par_bit_n    = par_bit;
    parity_err_n = o_parity_err;
`endif
    case (state)
      IDLE: begin
        if (rx_prev && !rx) begin
          state_n    = START;
          tick_cnt_n = '0;
        end
      end
      START: begin
        if (i_tick) begin
          if (tick_cnt == TICK_MID) begin
            tick_cnt_n = '0;
            bit_cnt_n  = '0;
            ferr_n     = 1'b0;
            state_n    = rx ? IDLE : DATA;
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
      end
      DATA: begin
        if (i_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_n = '0;
            shreg_n    = {rx, shreg[NB_DATA-1:1]};
            if (bit_cnt == DATA_LAST) begin
              bit_cnt_n = '0;
`ifdef UART_RX_PARITY_EN
              state_n   = PARITY;
`else
              state_n   = STOP;
`endif
            end else begin
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (i_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_n = '0;
            par_bit_n  = rx;
            state_n    = STOP;
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
      end
`endif
      STOP: begin
        if (i_tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_n = '0;
            if (!rx) ferr_n = 1'b1;
            if (bit_cnt == STOP_LAST) begin
              bit_cnt_n   = '0;
              state_n     = IDLE;
              valid_n     = 1'b1;
              data_n      = shreg;
              frame_err_n = ferr_n;
`ifdef UART_RX_PARITY_EN
              parity_err_n = ((^shreg) ^ par_bit) != 1'(PARITY_ODD);
`endif
            end else begin
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end else begin
            tick_cnt_n = tick_cnt + TW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Self-checking bench for uart_rx_cfg: default instance plus a 7-bit/2-stop instance,
// checked against a frame-level reference model.
module tb_uart_rx_cfg;

  localparam int OS     = 16;
  localparam int TDIV   = 4;
  localparam int BIT_CK = OS * TDIV;
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  typedef struct {
    logic [8:0] d;
    logic       fe;
    logic       pe;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tick = 1'b0;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic [7:0] d0;
  logic [6:0] d1;
  logic       v0, fe0, pe0, v1, fe1, pe1;

  int errors = 0;
  int checks = 0;
  rec_t got0[$];
  rec_t got1[$];

  uart_rx_cfg #(.NB_DATA(8), .NB_STOP(1), .OVERSAMPLE(OS), .PARITY_ODD(0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_rx_data(rx0),
    .o_data(d0), .o_valid(v0), .o_frame_err(fe0), .o_parity_err(pe0));

  uart_rx_cfg #(.NB_DATA(7), .NB_STOP(2), .OVERSAMPLE(OS), .PARITY_ODD(0)) dut1 (
    .i_clk(clk), .i_reset(rst), .i_tick(tick), .i_rx_data(rx1),
    .o_data(d1), .o_valid(v1), .o_frame_err(fe1), .o_parity_err(pe1));

  always #5 clk = ~clk;

  initial begin
    int c;
    c = 0;
    forever begin
      @(negedge clk);
      tick = (c == TDIV - 1);
      c = (c + 1) % TDIV;
    end
  end

  always @(negedge clk) begin
    if (v0) got0.push_back('{d: {1'b0, d0}, fe: fe0, pe: pe0});
    if (v1) got1.push_back('{d: {2'b0, d1}, fe: fe1, pe: pe1});
  end

  initial begin
    #5ms;
    $display("FAIL watchdog sim time exceeded");
    $fatal(1, "watchdog");
  end

  // Frame-level reference: what a receiver must report for a given serial frame.
  function automatic rec_t model(input logic [8:0] val, input int nb, input bit pbit,
                                 input bit stop_bad);
    rec_t r;
    logic [8:0] m;
    m    = 9'((1 << nb) - 1);
    r.d  = val & m;
    r.fe = stop_bad;
    r.pe = PAR_EN ? (((^r.d) ^ pbit) != 1'b0) : 1'b0;
    return r;
  endfunction

  task automatic set_line(input int sel, input logic b);
    if (sel == 0) rx0 = b; else rx1 = b;
  endtask

  task automatic clocks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame; when stop_bad is set the line is left low afterwards.
  task automatic send_frame(input int sel, input logic [8:0] val, input int nb, input int ns,
                            input bit pbit, input bit stop_bad);
    set_line(sel, 1'b0);
    clocks(BIT_CK);
    for (int i = 0; i < nb; i++) begin
      set_line(sel, val[i]);
      clocks(BIT_CK);
    end
    if (PAR_EN) begin
      set_line(sel, pbit);
      clocks(BIT_CK);
    end
    for (int i = 0; i < ns; i++) begin
      set_line(sel, !stop_bad);
      clocks(BIT_CK);
    end
    if (!stop_bad) set_line(sel, 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    clocks(3);
    set_line(0, 1'b0);
    clocks(2);
    set_line(0, 1'b1);
    clocks(2);
    checks++; if (d0 !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", d0); end
    checks++; if (v0 !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", v0); end
    checks++; if (fe0 !== 1'b0) begin errors++; $display("FAIL reset_ferr got=%b exp=0", fe0); end
    checks++; if (pe0 !== 1'b0) begin errors++; $display("FAIL reset_perr got=%b exp=0", pe0); end
    rst = 1'b0;
    clocks(BIT_CK);
    got0.delete();
    got1.delete();
  endtask

  task automatic test_basic;
    rec_t e, g;
    e = model(9'h055, 8, ^8'h55, 1'b0);
    send_frame(0, 9'h055, 8, 1, ^8'h55, 1'b0);
    clocks(BIT_CK);
    checks++; if (got0.size() !== 1) begin errors++; $display("FAIL basic_count got=%0d exp=1", got0.size()); end
    if (got0.size() > 0) begin
      g = got0.pop_front();
      checks++; if (g.d !== e.d) begin errors++; $display("FAIL basic_data got=%h exp=%h", g.d, e.d); end
      checks++; if (g.fe !== e.fe || g.pe !== e.pe) begin errors++;
        $display("FAIL basic_flags got=%b%b exp=%b%b", g.fe, g.pe, e.fe, e.pe); end
    end
    checks++; if (d0 !== 8'h55) begin errors++; $display("FAIL basic_hold got=%h exp=55", d0); end
    got0.delete();
  endtask

  task automatic test_glitch;
    rec_t e, g;
    set_line(0, 1'b0);
    clocks(5 * TDIV);
    set_line(0, 1'b1);
    clocks(2 * BIT_CK);
    checks++; if (got0.size() !== 0) begin errors++; $display("FAIL glitch_novalid got=%0d exp=0", got0.size()); end
    got0.delete();
    e = model(9'h0A3, 8, ^8'hA3, 1'b0);
    send_frame(0, 9'h0A3, 8, 1, ^8'hA3, 1'b0);
    clocks(BIT_CK);
    checks++; if (got0.size() !== 1) begin errors++; $display("FAIL glitch_next_count got=%0d exp=1", got0.size()); end
    if (got0.size() > 0) begin
      g = got0.pop_front();
      checks++; if (g != e) begin errors++;
        $display("FAIL glitch_next_rec got=%h/%b%b exp=%h/%b%b", g.d, g.fe, g.pe, e.d, e.fe, e.pe); end
    end
    got0.delete();
  endtask

  task automatic test_break;
    rec_t e, g;
    e = model(9'h03C, 8, ^8'h3C, 1'b1);
    send_frame(0, 9'h03C, 8, 1, ^8'h3C, 1'b1);
    clocks(3 * 11 * BIT_CK);
    checks++; if (got0.size() !== 1) begin errors++; $display("FAIL break_count got=%0d exp=1", got0.size()); end
    if (got0.size() > 0) begin
      g = got0.pop_front();
      checks++; if (g.fe !== 1'b1 || g.d !== e.d) begin errors++;
        $display("FAIL break_rec got=%h/%b exp=%h/1", g.d, g.fe, e.d); end
    end
    checks++; if (fe0 !== 1'b1) begin errors++; $display("FAIL break_flag_hold got=%b exp=1", fe0); end
    got0.delete();
    set_line(0, 1'b1);
    clocks(BIT_CK);
    e = model(9'h012, 8, ^8'h12, 1'b0);
    send_frame(0, 9'h012, 8, 1, ^8'h12, 1'b0);
    clocks(BIT_CK);
    checks++; if (got0.size() !== 1) begin errors++; $display("FAIL break_restart_count got=%0d exp=1", got0.size()); end
    if (got0.size() > 0) begin
      g = got0.pop_front();
      checks++; if (g != e) begin errors++;
        $display("FAIL break_restart_rec got=%h/%b%b exp=%h/%b%b", g.d, g.fe, g.pe, e.d, e.fe, e.pe); end
    end
    got0.delete();
  endtask

  task automatic test_parity;
    rec_t g;
    for (int pb = 0; pb < 2; pb++) begin
      send_frame(0, 9'h007, 8, 1, pb[0], 1'b0);
      clocks(BIT_CK);
      checks++; if (got0.size() !== 1) begin errors++; $display("FAIL parity_count got=%0d exp=1", got0.size()); end
      if (got0.size() > 0) begin
        g = got0.pop_front();
        checks++; if (g.pe !== (pb == 0) || g.d !== 9'h007) begin errors++;
          $display("FAIL parity_err pbit=%0d got=%b/%h exp=%b/007", pb, g.pe, g.d, (pb == 0)); end
      end
      got0.delete();
    end
  endtask

  task automatic test_back_to_back;
    rec_t g;
    send_frame(1, 9'h041, 7, 2, ^7'h41, 1'b0);
    send_frame(1, 9'h07F, 7, 2, ^7'h7F, 1'b0);
    clocks(BIT_CK);
    checks++; if (got1.size() !== 2) begin errors++; $display("FAIL b2b_count got=%0d exp=2", got1.size()); end
    if (got1.size() == 2) begin
      g = got1.pop_front();
      checks++; if (g != model(9'h041, 7, ^7'h41, 1'b0)) begin errors++;
        $display("FAIL b2b_first got=%h/%b%b exp=41/00", g.d, g.fe, g.pe); end
      g = got1.pop_front();
      checks++; if (g != model(9'h07F, 7, ^7'h7F, 1'b0)) begin errors++;
        $display("FAIL b2b_second got=%h/%b%b exp=7f/00", g.d, g.fe, g.pe); end
    end
    got1.delete();
  endtask

  task automatic test_reset_mid_frame;
    rec_t e, g;
    logic [7:0] v;
    v = 8'h5A;
    set_line(0, 1'b0);
    clocks(BIT_CK);
    for (int i = 0; i < 4; i++) begin
      set_line(0, v[i]);
      clocks(BIT_CK);
    end
    set_line(0, v[4]);
    clocks(BIT_CK / 2);
    rst = 1'b1;
    #1;
    checks++; if ({d0, v0, fe0, pe0} !== 11'b0) begin errors++;
      $display("FAIL midreset_outputs got=%h/%b%b%b exp=00/000", d0, v0, fe0, pe0); end
    set_line(0, 1'b1);
    clocks(4);
    rst = 1'b0;
    clocks(BIT_CK);
    checks++; if (got0.size() !== 0) begin errors++; $display("FAIL midreset_novalid got=%0d exp=0", got0.size()); end
    got0.delete();
    e = model(9'h099, 8, ^8'h99, 1'b0);
    send_frame(0, 9'h099, 8, 1, ^8'h99, 1'b0);
    clocks(BIT_CK);
    checks++; if (got0.size() !== 1) begin errors++; $display("FAIL midreset_next_count got=%0d exp=1", got0.size()); end
    if (got0.size() > 0) begin
      g = got0.pop_front();
      checks++; if (g != e) begin errors++;
        $display("FAIL midreset_next_rec got=%h/%b%b exp=%h/%b%b", g.d, g.fe, g.pe, e.d, e.fe, e.pe); end
    end
    got0.delete();
  endtask

  task automatic test_random;
    rec_t exp0[$];
    rec_t exp1[$];
    rec_t g, e;
    for (int n = 0; n < 8; n++) begin
      logic [8:0] val;
      bit pb, sb;
      int sel, nb, ns;
      sel = n % 2;
      nb  = sel ? 7 : 8;
      ns  = sel ? 2 : 1;
      val = 9'($urandom_range(0, 255));
      sb  = ($urandom_range(0, 3) == 0);
      pb  = ($urandom_range(0, 3) == 0) ? !(^(val & 9'((1 << nb) - 1))) : ^(val & 9'((1 << nb) - 1));
      if (sel == 0) exp0.push_back(model(val, nb, pb, sb));
      else          exp1.push_back(model(val, nb, pb, sb));
      send_frame(sel, val, nb, ns, pb, sb);
      if (sb) clocks(BIT_CK / 2);
      set_line(sel, 1'b1);
      clocks(sb ? BIT_CK : $urandom_range(0, 40));
    end
    clocks(BIT_CK);
    checks++; if (got0.size() !== exp0.size() || got1.size() !== exp1.size()) begin errors++;
      $display("FAIL random_count got=%0d/%0d exp=%0d/%0d", got0.size(), got1.size(), exp0.size(), exp1.size()); end
    while (got0.size() > 0 && exp0.size() > 0) begin
      g = got0.pop_front();
      e = exp0.pop_front();
      checks++; if (g != e) begin errors++;
        $display("FAIL random_dut0 got=%h/%b%b exp=%h/%b%b", g.d, g.fe, g.pe, e.d, e.fe, e.pe); end
    end
    while (got1.size() > 0 && exp1.size() > 0) begin
      g = got1.pop_front();
      e = exp1.pop_front();
      checks++; if (g != e) begin errors++;
        $display("FAIL random_dut1 got=%h/%b%b exp=%h/%b%b", g.d, g.fe, g.pe, e.d, e.fe, e.pe); end
    end
  endtask

  initial begin
    clocks(2);
    test_reset;
    test_basic;
    test_glitch;
    test_break;
    if (PAR_EN) test_parity;
    test_back_to_back;
    test_reset_mid_frame;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
